// File: rtl/contador_monitor_if.sv
// contador_monitor_if: bundles the signals that a contador_monitor observes and produces.
//
// Observed counter stimulus: dut_reset, enable, mode[1:0], d[3:0]
// Observed counter outputs:  q[3:0], load
// Monitor results:           q_exp[3:0], carry, locked, err, err_count[ERR_W-1:0]
//
// master: the environment (drives the counter side, reads the monitor results)
// slave:  the monitor
interface contador_monitor_if #(
   parameter int unsigned ERR_W = 8
);
   logic             dut_reset;
   logic             enable;
   logic [1:0]       mode;
   logic [3:0]       d;
   logic [3:0]       q;
   logic             load;
   logic [3:0]       q_exp;
   logic             carry;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_count;

   modport master (
      output dut_reset, enable, mode, d, q, load,
      input  q_exp, carry, locked, err, err_count
   );

   modport slave (
      input  dut_reset, enable, mode, d, q, load,
      output q_exp, carry, locked, err, err_count
   );
endinterface

// File: rtl/contador_monitor.sv
// contador_monitor: receive-side monitor for the 4-bit mode counter.
//
// Predicts the counter's Q/load from its observed stimulus, compares the prediction with the
// observed outputs one cycle later, flags mismatches and keeps a saturating error count. The
// counter's half-cycle rco is regenerated as a registered full-cycle carry.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high monitor reset
//   mon_if   contador_monitor_if.slave (observed stimulus/outputs in, predictions/flags out)
// Parameters:
//   ERR_W     width of err_count
//   MISS_MAX  consecutive mismatches in TRACK before lock is dropped (1..15)
// Configuration macro:
//   MON_STICKY_EN  when defined, err latches on the first mismatch until reset_i;
//                  otherwise err is a one-cycle pulse per mismatch.
module contador_monitor #(
   parameter int unsigned ERR_W    = 8,
   parameter int unsigned MISS_MAX = 3
) (
   input logic               clk_i,
   input logic               reset_i,
   contador_monitor_if.slave mon_if
);

   localparam logic [3:0]       MissMax = 4'(MISS_MAX);
   localparam logic [ERR_W-1:0] ErrMax  = {ERR_W{1'b1}};

   typedef enum logic [0:0] {StSeek, StTrack} state_e;

   state_e           state_q, state_d;
   logic [3:0]       miss_q, miss_d;
   logic [3:0]       q_exp_q, q_exp_d;
   logic             ld_exp_q, ld_exp_d;
   logic             carry_q, carry_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             mismatch;
   logic [3:0]       ref_q;
   logic             ref_ld;
   logic [3:0]       miss_inc;

   // Comparison and choice of the reference the counter model is applied to.
   always_comb begin
      mismatch = (state_q == StTrack) &&
                 ((mon_if.q != q_exp_q) || (mon_if.load != ld_exp_q));
      // In SEEK the observation is adopted; in TRACK a miss resynchronizes to it.
      if ((state_q == StSeek) || mismatch) begin
         ref_q  = mon_if.q;
         ref_ld = mon_if.load;
      end else begin
         ref_q  = q_exp_q;
         ref_ld = ld_exp_q;
      end
   end

   // Counter model; dut_reset wins over every mode.
   always_comb begin
      q_exp_d  = ref_q;
      ld_exp_d = ref_ld;
      carry_d  = 1'b0;
      if (mon_if.dut_reset) begin
         q_exp_d  = 4'd0;
         ld_exp_d = 1'b0;
      end else begin
         unique case (mon_if.mode)
            2'b00: begin
               if (mon_if.enable) begin
                  q_exp_d  = ref_q + 4'd1;
                  ld_exp_d = 1'b0;
                  carry_d  = (q_exp_d == 4'hF);
               end
            end
            2'b01: begin
               q_exp_d  = ref_q - 4'd1;
               ld_exp_d = 1'b0;
               carry_d  = (q_exp_d == 4'h0);
            end
            2'b10: begin
               q_exp_d  = ref_q + 4'd3;
               ld_exp_d = 1'b0;
               carry_d  = (q_exp_d == 4'hF);
            end
            2'b11: begin
               q_exp_d  = mon_if.d;
               ld_exp_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // FSM: state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StSeek;
         miss_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
      end
   end

   // FSM: next state.
   assign miss_inc = miss_q + 4'd1;

   always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      unique case (state_q)
         StSeek: begin
            state_d = StTrack;
            miss_d  = 4'd0;
         end
         StTrack: begin
            if (mismatch) begin
               if (miss_inc >= MissMax) begin
                  state_d = StSeek;
                  miss_d  = 4'd0;
               end else begin
                  miss_d = miss_inc;
               end
            end else begin
               miss_d = 4'd0;
            end
         end
         default: begin
            state_d = StSeek;
            miss_d  = 4'd0;
         end
      endcase
   end

   // FSM: outputs. locked rises one cycle after leaving SEEK, falls on the edge entering it.
   always_comb begin
      locked_d = (state_q == StTrack) && (state_d == StTrack);
`ifdef MON_STICKY_EN
      err_d = err_q | mismatch;
`else
      err_d = mismatch;
`endif
      err_cnt_d = err_cnt_q;
      if (mismatch && (err_cnt_q != ErrMax)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_exp_q   <= 4'd0;
         ld_exp_q  <= 1'b0;
         carry_q   <= 1'b0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         q_exp_q   <= q_exp_d;
         ld_exp_q  <= ld_exp_d;
         carry_q   <= carry_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign mon_if.q_exp     = q_exp_q;
   assign mon_if.carry     = carry_q;
   assign mon_if.locked    = locked_q;
   assign mon_if.err       = err_q;
   assign mon_if.err_count = err_cnt_q;

endmodule

// File: tb/tb_contador_monitor.sv
// Bench for contador_monitor: a behavioural counter (with fault injection) feeds the monitor;
// a reference model of the monitor pushes expected outputs per cycle into a queue that an
// independent checker drains.
module tb_contador_monitor;

   localparam int unsigned ERR_W    = 4;
   localparam int unsigned MISS_MAX = 3;
   localparam int          ERR_MAX  = (1 << ERR_W) - 1;
`ifdef MON_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {
      int q_exp;
      int carry;
      int locked;
      int err;
      int err_count;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   contador_monitor_if #(.ERR_W(ERR_W)) mon_if ();

   contador_monitor #(
      .ERR_W   (ERR_W),
      .MISS_MAX(MISS_MAX)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .mon_if (mon_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];

   // Counter rules, straight from the mode table.
   function automatic void spec_step(input int q, input int ld, input bit rst, input bit en,
                                     input int md, input int d,
                                     output int nq, output int nld, output int nc);
      nq = q; nld = ld; nc = 0;
      if (rst) begin
         nq = 0; nld = 0;
      end else begin
         case (md)
            0: if (en) begin nq = (q + 1) % 16; nld = 0; nc = (nq == 15); end
            1: begin nq = (q + 15) % 16; nld = 0; nc = (nq == 0); end
            2: begin nq = (q + 3) % 16; nld = 0; nc = (nq == 15); end
            default: begin nq = d; nld = 1; end
         endcase
      end
   endfunction

   // Counter under observation; fault_mask/fault_ld corrupt its next state.
   logic [3:0] cnt_q = 4'd7;
   logic       ld_q  = 1'b0;
   logic [3:0] fault_mask = 4'd0;
   logic       fault_ld   = 1'b0;
   int c_nq, c_nld, c_nc;

   always_comb begin
      c_nq = 0; c_nld = 0; c_nc = 0;
      spec_step(int'(cnt_q), int'(ld_q), mon_if.dut_reset, mon_if.enable, int'(mon_if.mode),
                int'(mon_if.d), c_nq, c_nld, c_nc);
   end

   always @(posedge clk) begin
      cnt_q <= 4'(c_nq) ^ fault_mask;
      ld_q  <= (c_nld != 0) ^ fault_ld;
   end

   assign mon_if.q    = cnt_q;
   assign mon_if.load = ld_q;

   // Reference monitor state. In TRACK the reference is always the observation: either it
   // matched the prediction or the monitor resynchronized to it.
   bit m_track = 0, m_err = 0, m_locked = 0;
   int m_miss = 0, m_pq = 0, m_pld = 0, m_pc = 0, m_errs = 0;

   task automatic model(input bit rst, input bit drst, input bit en, input int md, input int d);
      exp_t e;
      bit mis;
      int nq, nld, nc;
      if (rst) begin
         m_track = 0; m_miss = 0; m_pq = 0; m_pld = 0; m_pc = 0;
         m_err = 0; m_errs = 0; m_locked = 0;
      end else begin
         if (m_track) begin
            mis = (int'(cnt_q) != m_pq) || (int'(ld_q) != m_pld);
            if (mis) begin
               m_miss++;
               if (m_errs < ERR_MAX) m_errs++;
            end else begin
               m_miss = 0;
            end
            m_err = STICKY ? (m_err || mis) : mis;
            if (m_miss == MISS_MAX) begin
               m_track = 0; m_miss = 0; m_locked = 0;
            end else begin
               m_locked = 1;
            end
         end else begin
            m_track = 1; m_locked = 0;
            if (!STICKY) m_err = 0;
         end
         spec_step(int'(cnt_q), int'(ld_q), drst, en, md, d, nq, nld, nc);
         m_pq = nq; m_pld = nld; m_pc = nc;
      end
      e.q_exp = m_pq; e.carry = m_pc; e.locked = m_locked;
      e.err = m_err; e.err_count = m_errs;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive away from the edge, record the expectation, take the edge.
   task automatic drive(input bit rst, input bit drst, input bit en, input int md, input int d,
                        input int fmask, input bit fld);
      @(negedge clk);
      reset            = rst;
      mon_if.dut_reset = drst;
      mon_if.enable    = en;
      mon_if.mode      = 2'(md);
      mon_if.d         = 4'(d);
      fault_mask       = 4'(fmask);
      fault_ld         = fld;
      model(rst, drst, en, md, d);
      @(posedge clk);
   endtask

   // Checker: one expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q_exp", int'(mon_if.q_exp), e.q_exp);
            check("carry", int'(mon_if.carry), e.carry);
            check("locked", int'(mon_if.locked), e.locked);
            check("err", int'(mon_if.err), e.err);
            check("err_count", int'(mon_if.err_count), e.err_count);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      mon_if.dut_reset = 1'b0;
      mon_if.enable    = 1'b0;
      mon_if.mode      = 2'b00;
      mon_if.d         = 4'd0;

      repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      repeat (16) drive(0, 0, 1, 0, 0, 0, 0);

      drive(0, 0, 0, 3, 'hA, 0, 0);
      repeat (11) drive(0, 0, 0, 1, 0, 0, 0);

      drive(0, 0, 0, 3, 14, 0, 0);
      drive(0, 0, 0, 2, 0, 0, 0);
      drive(0, 0, 0, 3, 12, 0, 0);
      drive(0, 0, 0, 2, 0, 0, 0);

      // Single corruption, then clean counting.
      drive(0, 0, 1, 0, 0, 5, 0);
      repeat (4) drive(0, 0, 1, 0, 0, 0, 0);

      // Three consecutive corruptions drop lock; then relock.
      repeat (3) drive(0, 0, 1, 0, 0, 3, 0);
      repeat (4) drive(0, 0, 1, 0, 0, 0, 0);

      drive(0, 0, 1, 0, 0, 8, 0);
      repeat (2) drive(0, 0, 1, 0, 0, 0, 0);
      #1;
      check("err_count_before_reset", int'(mon_if.err_count), 5);
      check("locked_before_reset", int'(mon_if.locked), 1);

      drive(1, 0, 1, 0, 0, 0, 0);
      repeat (3) drive(0, 0, 1, 0, 0, 0, 0);

      for (int i = 0; i < 1500; i++) begin
         drive(($urandom % 64) == 0, ($urandom % 16) == 0, 1'($urandom), int'($urandom % 4),
               int'($urandom % 16),
               (($urandom % 8) == 0) ? int'($urandom_range(1, 15)) : 0,
               ($urandom % 16) == 0);
      end

      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/contador_monitor.md
# contador_monitor

Synthesizable receive-side monitor for the 4-bit mode counter (`contador`). It sits beside a counter instance and observes the counter's stimulus (`dut_reset`, `enable`, `mode`, `D`) and outputs (`Q`, `load`). From these it predicts the counter's behaviour, flags deviations, and keeps a saturating error count. It also regenerates the counter's half-cycle `rco` pulse as a full-cycle `carry` for cascaded stages.

## Interface
- `ERR_W`, default 8: width of `err_count`.
- `MISS_MAX`, default 3: consecutive mismatches in TRACK before lock is dropped; legal range 1..15.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high monitor reset.
- `dut_reset` in 1: the counter's own reset, as driven to the counter.
- `enable` in 1: the counter's enable, as driven.
- `mode` in 2: the counter's mode, as driven.
- `D` in 4: the counter's load data, as driven.
- `Q` in 4: counter value output.
- `load` in 1: counter load flag output.
- `q_exp` out 4: predicted counter value for the current cycle.
- `carry` out 1: full-cycle regenerated carry.
- `locked` out 1: the monitor is tracking.
- `err` out 1: mismatch indication.
- `err_count` out `ERR_W`: saturating mismatch count.

## Operation
- The counter model is applied at each edge from the sampled stimulus and the current `q_exp`. `dut_reset` has priority in every mode.
- `dut_reset`=1: next Q=0, load=0, carry=0.
- Mode 00: if `enable`, next Q=Q+1 and load=0. If not `enable`, Q and load hold. carry=1 iff `enable` and next Q==15.
- Mode 01: next Q=Q−1, ignoring `enable`. load=0. carry=1 iff next Q==0.
- Mode 10: next Q=Q+3, ignoring `enable`. load=0. carry=1 iff next Q==15.
- Mode 11: next Q=D, load=1, carry=0.
- All arithmetic is modulo 16; 15+1→0, 0−1→15, 14+3→1.
- FSM has two states, SEEK and TRACK. Reset state is SEEK.
- SEEK: no comparison is made. If `dut_reset` is sampled or mode 11 is sampled, the prediction is exact. Otherwise the monitor adopts the observed `Q` and `load` as the reference. It then applies the model and moves to TRACK. `locked`=0 in SEEK.
- TRACK: the observed `Q` and `load` are compared with the previous prediction (`q_exp` and the expected load).
  - On a mismatch: `err` fires, `err_count` increments, and the miss counter increments. The prediction is resynchronized to the observed values before the model is applied.
  - On a match: the miss counter clears.
  - When the miss counter reaches `MISS_MAX`: go to SEEK and clear the miss counter.
- `err_count` saturates at 2^ERR_W−1 and never wraps.
- `reset` is honored in any state, including mid-run. It returns all state to reset values on the same edge.

## Timing
- Reset values: `q_exp`=0, `carry`=0, `locked`=0, `err`=0, `err_count`=0, expected load=0, miss counter=0, state=SEEK.
- Stimulus is sampled at edge N, the same edge at which the counter updates. `q_exp` and `carry` update at edge N and are cycle-aligned with the counter's `Q`.
- The comparison of the `Q` produced at edge N happens at edge N+1. `err` is registered, so it is high during cycle N+1..N+2: one cycle of latency after the counter's update edge.
- `carry` is high for exactly the full cycle in which the counter's `rco` pulse begins.
- `locked` rises one cycle after leaving SEEK. It falls on the edge that enters SEEK.
- When `dut_reset` and a mismatch coincide at a comparison edge, the error is counted. The prediction for that edge still comes from the reset rule.

## Configuration
- `MON_STICKY_EN` defined:
  - `err` latches high on the first mismatch and stays high until `reset`.
  - `err_count` still counts every mismatch.
- `MON_STICKY_EN` undefined:
  - `err` is a one-cycle pulse per mismatch.
  - Back-to-back mismatches hold `err` high continuously.

## Test plan
- Reset, then `dut_reset` for 1 cycle, then mode 00 with `enable`=1 for 16 cycles against a correct counter:
  - `q_exp` steps 0→15.
  - `carry` is high only in the cycle where Q=15.
  - `err`=0, `locked`=1 from cycle 2.
- Mode 11 with D=4'hA, then mode 01 for 11 cycles:
  - Expected load=1, then 0.
  - Q counts A→0→F.
  - `carry` is high only at Q=0. No errors.
- Mode 10 starting from Q=14: next Q=1, `carry`=0. From Q=12: next Q=15, `carry`=1.
- Force `Q` wrong once in TRACK:
  - `err` pulses one cycle later and `err_count`=1.
  - Subsequent cycles match and `locked` stays 1.
  - With `MON_STICKY_EN`, `err` stays 1.
- Force `Q` wrong for 3 consecutive cycles:
  - `err_count`=3, and `locked` drops on the third miss.
  - The monitor relocks after one SEEK sample.
- Assert `reset` mid-count with `err_count`=5: all outputs go to reset values on the next edge, and state returns to SEEK.
